jbus_txn_tracker: RTL

Synthesizable, parametrised successor to the PLI-based JBus monitor: tracks every bus cycle in hardware, checks address/data parity, counts outstanding reads per port, enforces burst lengths and read-return timeouts, and reports bus idle / uncompleted-access status. It sits beside the JBus at system top level, connected to the shared bus signals. It is usable in emulation and FPGA builds where PLI is unavailable.

---
 rtl/jbus_trk_pkg.sv | 55 +++++
 rtl/jbus_parity_chk.sv | 21 ++
 rtl/jbus_txn_tracker.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/jbus_trk_pkg.sv
// Shared definitions for the JBus transaction tracker: adtype field layout,
// cycle classes, FSM states and error codes.
package jbus_trk_pkg;

  localparam logic [7:0] ADTYPE_IDLE = 8'hFF;
  localparam int TYPE_HI = 7;
  localparam int TYPE_LO = 6;
  localparam int CMD_HI  = 5;
  localparam int CMD_LO  = 3;
  localparam int PORT_HI = 2;
  localparam int PORT_LO = 0;

  typedef enum logic [2:0] {
    CMD_READ  = 3'd0,
    CMD_WRITE = 3'd1
  } jbus_cmd_e;

  typedef enum logic [1:0] {
    CYC_IDLE = 2'd0,
    CYC_REQ  = 2'd1,
    CYC_DATA = 2'd2,
    CYC_RET  = 2'd3
  } cyc_class_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WDATA = 2'd1,
    ST_RDATA = 2'd2
  } trk_state_e;

  localparam logic [2:0] ERR_NONE        = 3'd0;
  localparam logic [2:0] ERR_PARITY      = 3'd1;
  localparam logic [2:0] ERR_SHORT_BURST = 3'd2;
  localparam logic [2:0] ERR_STRAY_DATA  = 3'd3;
  localparam logic [2:0] ERR_OVERFLOW    = 3'd4;
  localparam logic [2:0] ERR_UNEXP_RET   = 3'd5;
  localparam logic [2:0] ERR_TIMEOUT     = 3'd6;
  localparam logic [2:0] ERR_BAD_PORT    = 3'd7;

  // Any 00-type code other than all-ones is still treated as an idle cycle.
  function automatic cyc_class_e decode_class(input logic [7:0] adtype);
    cyc_class_e cls;
    cls = CYC_IDLE;
    if (adtype != ADTYPE_IDLE) begin
      case (adtype[TYPE_HI:TYPE_LO])
        2'b01:   cls = CYC_REQ;
        2'b10:   cls = CYC_DATA;
        2'b11:   cls = CYC_RET;
        default: cls = CYC_IDLE;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/jbus_parity_chk.sv
// Even-parity compare of each 32-bit slice of j_ad against its j_adp bit.
module jbus_parity_chk #(
  parameter int AD_WIDTH = 128
) (
  input  logic [AD_WIDTH-1:0]    ad,
  input  logic [AD_WIDTH/32-1:0] adp,
  output logic                   mismatch
);

  logic [AD_WIDTH/32-1:0] calc;

  always_comb begin
    calc = '0;
    for (int i = 0; i < AD_WIDTH/32; i++) begin
      calc[i] = ^ad[32*i +: 32];
    end
  end

  assign mismatch = |(calc ^ adp);

endmodule

// File: rtl/jbus_txn_tracker.sv
// JBus cycle tracker: burst FSM, per-port outstanding reads, read timeout and
// error reporting. Define JBUS_TRACK_PARITY_EN to build in the parity checker.
module jbus_txn_tracker
  import jbus_trk_pkg::*;
#(
  parameter int NUM_PORTS   = 7,
  parameter int AD_WIDTH    = 128,
  parameter int OUTST_DEPTH = 16,
  parameter int WR_BEATS    = 4,
  parameter int RD_BEATS    = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                                          jbus_j_clk,
  input  logic                                          jbus_j_rst,
  input  logic [AD_WIDTH-1:0]                           jbus_j_ad,
  input  logic [AD_WIDTH/32-1:0]                        jbus_j_adp,
  input  logic [7:0]                                    jbus_j_adtype,
  output logic                                          bus_is_idle,
  output logic                                          uncompleted_accesses,
  output logic [NUM_PORTS*$clog2(OUTST_DEPTH+1)-1:0]    outst_cnt,
  output logic                                          err_valid,
  output logic [2:0]                                    err_code,
  output logic [2:0]                                    err_port,
  output logic [15:0]                                   err_count
);

  localparam int CW = $clog2(OUTST_DEPTH + 1);
  localparam int BW = $clog2(((WR_BEATS > RD_BEATS) ? WR_BEATS : RD_BEATS) + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [3:0] NP = 4'(NUM_PORTS);

  trk_state_e    state_q, state_d;
  logic [BW-1:0] beats_q, beats_d;
  logic [2:0]    burst_port_q, burst_port_d;
  logic [CW-1:0] outst_q [NUM_PORTS];
  logic [CW-1:0] outst_d [NUM_PORTS];
  logic [TW-1:0] timer_q, timer_d;
  logic          err_valid_q, err_valid_d;
  logic [2:0]    err_code_q, err_code_d;
  logic [2:0]    err_port_q, err_port_d;
  logic [15:0]   err_count_q, err_count_d;
  logic          bus_idle_q, bus_idle_d;
  logic          unc_q, unc_d;

  cyc_class_e cls;
  logic [2:0] port;
  logic [2:0] cmd;
  logic       is_hdr;
  logic       bad_port;
  logic       parity_err;
  logic       any_outst;
  logic [7:1] err_flags;

  assign cls  = decode_class(jbus_j_adtype);
  assign port = jbus_j_adtype[PORT_HI:PORT_LO];
  assign cmd  = jbus_j_adtype[CMD_HI:CMD_LO];

`ifdef JBUS_TRACK_PARITY_EN
  jbus_parity_chk #(.AD_WIDTH(AD_WIDTH)) u_parity (
    .ad       (jbus_j_ad),
    .adp      (jbus_j_adp),
    .mismatch (parity_err)
  );
`else
  logic unused_bus;
  assign unused_bus = ^{jbus_j_ad, jbus_j_adp};
  assign parity_err = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    beats_d      = beats_q;
    burst_port_d = burst_port_q;
    outst_d      = outst_q;
    timer_d      = timer_q;
    err_flags    = '0;
    err_code_d   = ERR_NONE;
    err_port_d   = 3'd0;
    any_outst    = 1'b0;
    unc_d        = 1'b0;
    is_hdr       = (cls == CYC_REQ) || (cls == CYC_RET);
    bad_port     = is_hdr && ({1'b0, port} >= NP);

    for (int p = 0; p < NUM_PORTS; p++) begin
      if (outst_q[p] != '0) any_outst = 1'b1;
    end

    if (parity_err && (cls != CYC_IDLE)) err_flags[ERR_PARITY] = 1'b1;

    if (state_q != ST_IDLE) begin
      if (cls == CYC_DATA) begin
        beats_d = beats_q - 1'b1;
        if (beats_q == BW'(1)) state_d = ST_IDLE;
      end else begin
        err_flags[ERR_SHORT_BURST] = 1'b1;
        state_d = ST_IDLE;
        beats_d = '0;
      end
    end else if (cls == CYC_DATA) begin
      err_flags[ERR_STRAY_DATA] = 1'b1;
    end

    // A header aborting a burst is handled exactly as if seen from IDLE.
    if (is_hdr) begin
      if (bad_port) err_flags[ERR_BAD_PORT] = 1'b1;
      if (cls == CYC_RET) begin
        state_d      = ST_RDATA;
        beats_d      = BW'(RD_BEATS);
        burst_port_d = port;
      end else if (cmd == CMD_WRITE) begin
        state_d      = ST_WDATA;
        beats_d      = BW'(WR_BEATS);
        burst_port_d = port;
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (!bad_port && (port == 3'(p))) begin
          if ((cls == CYC_REQ) && (cmd == CMD_READ)) begin
            if (outst_q[p] == CW'(OUTST_DEPTH)) err_flags[ERR_OVERFLOW] = 1'b1;
            else outst_d[p] = outst_q[p] + 1'b1;
          end
          if (cls == CYC_RET) begin
            if (outst_q[p] == '0) err_flags[ERR_UNEXP_RET] = 1'b1;
            else outst_d[p] = outst_q[p] - 1'b1;
          end
        end
      end
    end

    if ((cls == CYC_RET) || !any_outst) begin
      timer_d = '0;
    end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
      err_flags[ERR_TIMEOUT] = 1'b1;
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end

    for (int c = 7; c >= 1; c--) begin
      if (err_flags[c]) err_code_d = 3'(c);
    end
    case (err_code_d)
      ERR_PARITY:      err_port_d = is_hdr ? port : 3'd0;
      ERR_SHORT_BURST: err_port_d = burst_port_q;
      ERR_OVERFLOW,
      ERR_UNEXP_RET,
      ERR_BAD_PORT:    err_port_d = port;
      default:         err_port_d = 3'd0;
    endcase
    err_valid_d = |err_flags;
    err_count_d = err_count_q + 16'((err_valid_d && (err_count_q != 16'hFFFF)) ? 1 : 0);

    for (int p = 0; p < NUM_PORTS; p++) begin
      if (outst_d[p] != '0) unc_d = 1'b1;
    end
    bus_idle_d = (state_q == ST_IDLE) && (cls == CYC_IDLE);
  end

  always_ff @(posedge jbus_j_clk or posedge jbus_j_rst) begin
    if (jbus_j_rst) begin
      state_q      <= ST_IDLE;
      beats_q      <= '0;
      burst_port_q <= 3'd0;
      outst_q      <= '{default: '0};
      timer_q      <= '0;
      err_valid_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
      err_port_q   <= 3'd0;
      err_count_q  <= 16'd0;
      bus_idle_q   <= 1'b1;
      unc_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      beats_q      <= beats_d;
      burst_port_q <= burst_port_d;
      outst_q      <= outst_d;
      timer_q      <= timer_d;
      err_valid_q  <= err_valid_d;
      err_code_q   <= err_code_d;
      err_port_q   <= err_port_d;
      err_count_q  <= err_count_d;
      bus_idle_q   <= bus_idle_d;
      unc_q        <= unc_d;
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_pack
    assign outst_cnt[g*CW +: CW] = outst_q[g];
  end

  assign bus_is_idle          = bus_idle_q;
  assign uncompleted_accesses = unc_q;
  assign err_valid            = err_valid_q;
  assign err_code             = err_code_q;
  assign err_port             = err_port_q;
  assign err_count            = err_count_q;

endmodule
